// File: rtl/ad_pn_pkg.sv
// ad_pn_pkg: shared definitions for the PN-test lock path.
//   - pn_state_e : lock controller state encoding (also exported as pn_state)
//   - PN*_MASK   : generator polynomial masks. Bit k set means tap x^k, so the
//                  new bit is the XOR of the bits k positions back.
package ad_pn_pkg;

  typedef enum logic [1:0] {
    PN_IDLE   = 2'd0,
    PN_SEARCH = 2'd1,
    PN_LOCKED = 2'd2
  } pn_state_e;

  localparam logic [31:0] PN7_MASK  = 32'h0000_00C0; // x^7  + x^6  + 1
  localparam logic [31:0] PN9_MASK  = 32'h0000_0220; // x^9  + x^5  + 1
  localparam logic [31:0] PN15_MASK = 32'h0000_C000; // x^15 + x^14 + 1
  localparam logic [31:0] PN23_MASK = 32'h0084_0000; // x^23 + x^18 + 1
  localparam logic [31:0] PN31_MASK = 32'h9000_0000; // x^31 + x^28 + 1

endpackage

// File: rtl/ad_pngen.sv
// ad_pngen: parallel PN generator producing DW bits per enabled clock.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (state cleared to 0)
//   clk_en       : advance enable, one word per enabled cycle
//   pn_init      : reseed from the last POL_W bits of pn_data_in instead of
//                  free-running
//   pn_data_in   : incoming word (MSB oldest)
//   pn_data_out  : predicted next word (MSB oldest), combinational from state
module ad_pngen
  import ad_pn_pkg::*;
#(
  parameter logic [31:0] POL_MASK = PN7_MASK,
  parameter int          POL_W    = 7,
  parameter int          DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          pn_init,
  input  logic [DW-1:0] pn_data_in,
  output logic [DW-1:0] pn_data_out
);

  if (DW < POL_W) begin : g_dw_chk
    $error("ad_pngen: DW must be >= POL_W");
  end

  // state_q[i] holds the bit i positions back from the newest one.
  logic [POL_W-1:0] state_q, state_d;
  logic [POL_W-1:0] walk;
  logic             fb;
  logic [DW-1:0]    pred;

  // Unroll DW LFSR steps; the first generated bit is the oldest (MSB).
  always_comb begin
    walk = state_q;
    fb   = 1'b0;
    pred = '0;
    for (int j = 0; j < DW; j++) begin
      fb   = ^(walk & POL_MASK[POL_W:1]);
      walk = {walk[POL_W-2:0], fb};
      pred[DW-1-j] = fb;
    end
  end

  // After a word the generator state is simply that word's newest POL_W bits.
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      state_d = pn_init ? pn_data_in[POL_W-1:0] : pred[POL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign pn_data_out = pred;

endmodule

// File: rtl/ad_pn_sync_ctrl.sv
// ad_pn_sync_ctrl: lock controller for the parallel PN generator.
// Seeds the generator from the incoming stream, qualifies lock over LOCK_CNT
// consecutive matching words, then counts errors and drops lock after OOS_CNT
// consecutive mismatches.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   adc_valid   : word qualifier; a word is consumed on every clk with
//                 adc_valid=1, and nothing advances when it is 0 (no back-pressure)
//   adc_data    : sampled word, MSB oldest
//   cfg_enable  : checker enable, 0 forces IDLE
//   err_clr     : synchronous clear of err_count (wins over an increment)
//   pn_oos      : out-of-sync status (registered)
//   pn_err      : one-cycle pulse per mismatching word while LOCKED
//   err_count   : saturating mismatch count while LOCKED
//   pn_state    : FSM state (0 IDLE, 1 SEARCH, 2 LOCKED)
module ad_pn_sync_ctrl
  import ad_pn_pkg::*;
#(
  parameter logic [31:0] POL_MASK  = PN7_MASK,
  parameter int          POL_W     = 7,
  parameter int          DW        = 16,
  parameter int          LOCK_CNT  = 16,
  parameter int          OOS_CNT   = 8,
  parameter int          ERR_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_valid,
  input  logic [DW-1:0]        adc_data,
  input  logic                 cfg_enable,
  input  logic                 err_clr,
  output logic                 pn_oos,
  output logic                 pn_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           pn_state
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] OOS_LAST  = 8'(OOS_CNT - 1);

  pn_state_e            state_q;
  logic [7:0]           match_cnt_q;
  logic [7:0]           miss_cnt_q;
  logic                 seed_vld_q;
  logic                 pn_oos_q;
  logic                 pn_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [DW-1:0]        pn_expected;
  logic                 match;
  logic                 pn_init;

  // All-zero never matches so a stuck bus cannot fake a lock.
  assign match   = seed_vld_q && (adc_data == pn_expected) && (|adc_data);
  // Reseed on every failed prediction while searching.
  assign pn_init = (state_q == PN_SEARCH) && !match;

  ad_pngen #(
    .POL_MASK (POL_MASK),
    .POL_W    (POL_W),
    .DW       (DW)
  ) u_pngen (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (adc_valid),
    .pn_init     (pn_init),
    .pn_data_in  (adc_data),
    .pn_data_out (pn_expected)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PN_IDLE;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      seed_vld_q  <= 1'b0;
      pn_oos_q    <= 1'b1;
      pn_err_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pn_err_q <= 1'b0;
      if (!cfg_enable) begin
        state_q     <= PN_IDLE;
        match_cnt_q <= '0;
        miss_cnt_q  <= '0;
        seed_vld_q  <= 1'b0;
        pn_oos_q    <= 1'b1;
      end else begin
        unique case (state_q)
          PN_IDLE: begin
            state_q  <= PN_SEARCH;
            pn_oos_q <= 1'b1;
          end
          PN_SEARCH: begin
            if (adc_valid) begin
              if (match) begin
                if (match_cnt_q == LOCK_LAST) begin
                  state_q     <= PN_LOCKED;
                  pn_oos_q    <= 1'b0;
                  match_cnt_q <= '0;
                end else begin
                  match_cnt_q <= match_cnt_q + 8'd1;
                end
              end else begin
                match_cnt_q <= '0;
                seed_vld_q  <= 1'b1;
              end
            end
          end
          PN_LOCKED: begin
            if (adc_valid) begin
              if (match) begin
                miss_cnt_q <= '0;
              end else begin
                pn_err_q <= 1'b1;
                if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
                if (miss_cnt_q == OOS_LAST) begin
                  state_q    <= PN_SEARCH;
                  pn_oos_q   <= 1'b1;
                  seed_vld_q <= 1'b0;
                  miss_cnt_q <= '0;
                end else begin
                  miss_cnt_q <= miss_cnt_q + 8'd1;
                end
              end
            end
          end
          default: state_q <= PN_IDLE;
        endcase
      end
      if (err_clr) err_cnt_q <= '0;
    end
  end

  assign pn_oos    = pn_oos_q;
  assign pn_err    = pn_err_q;
  assign err_count = err_cnt_q;
  assign pn_state  = state_q;

endmodule

// File: tb/tb_ad_pn_sync_ctrl.sv
// tb_ad_pn_sync_ctrl: directed bench for ad_pn_sync_ctrl (PN7, DW=16).
// A second instance with a 3-bit error counter shares the stimulus so counter
// saturation is reachable in a short run.
module tb_ad_pn_sync_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_enable, err_clr, adc_valid;
  logic [15:0] adc_data;

  logic        pn_oos, pn_err, pn_oos_s, pn_err_s;
  logic [31:0] err_count;
  logic [2:0]  err_count_s;
  logic [1:0]  pn_state, pn_state_s;

  ad_pn_sync_ctrl dut (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .cfg_enable(cfg_enable), .err_clr(err_clr), .pn_oos(pn_oos),
    .pn_err(pn_err), .err_count(err_count), .pn_state(pn_state)
  );

  ad_pn_sync_ctrl #(.ERR_CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .cfg_enable(cfg_enable), .err_clr(err_clr), .pn_oos(pn_oos_s),
    .pn_err(pn_err_s), .err_count(err_count_s), .pn_state(pn_state_s)
  );

  // ---------------- golden PN7 sequence ----------------
  bit seq [127];

  function automatic logic [15:0] gw(input int k);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[15-j] = seq[(16 * (k % 127) + j) % 127];
    return r;
  endfunction

  // Word that follows w in the m-sequence, located by searching for w's
  // newest 7 bits; 0 when that tail never occurs (all zero).
  function automatic logic [15:0] next_word(input logic [15:0] w);
    logic [15:0] r;
    int          n;
    bit          hit, ok;
    r = '0; n = 0; hit = 1'b0; ok = 1'b0;
    for (int i = 0; i < 127; i++) begin
      if (!hit) begin
        ok = 1'b1;
        for (int k = 0; k < 7; k++) if (seq[(i + k) % 127] != w[6-k]) ok = 1'b0;
        if (ok) begin hit = 1'b1; n = i; end
      end
    end
    if (hit) for (int j = 0; j < 16; j++) r[15-j] = seq[(n + 7 + j) % 127];
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [1:0]  m_state;
  logic        m_oos, m_err, m_seed;
  logic [31:0] m_cnt;
  logic [2:0]  m_cnt_s;
  int          m_match, m_miss;
  logic [15:0] m_pred;

  task automatic model_update(input logic v, input logic [15:0] d);
    logic        mt;
    logic [15:0] pn;
    if (reset) begin
      m_state = 2'd0; m_oos = 1'b1; m_err = 1'b0; m_seed = 1'b0;
      m_cnt = '0; m_cnt_s = '0; m_match = 0; m_miss = 0; m_pred = '0;
    end else begin
      mt = v && m_seed && (d == m_pred) && (d != 16'h0);
      pn = m_pred;
      if (v) pn = (m_state == 2'd1 && !mt) ? next_word(d) : next_word(m_pred);
      m_err = 1'b0;
      if (!cfg_enable) begin
        m_state = 2'd0; m_match = 0; m_miss = 0; m_seed = 1'b0; m_oos = 1'b1;
      end else if (m_state == 2'd0) begin
        m_state = 2'd1;
      end else if (m_state == 2'd1 && v) begin
        if (mt) begin
          if (m_match == 15) begin m_state = 2'd2; m_oos = 1'b0; m_match = 0; end
          else m_match++;
        end else begin
          m_match = 0; m_seed = 1'b1;
        end
      end else if (m_state == 2'd2 && v) begin
        if (mt) m_miss = 0;
        else begin
          m_err = 1'b1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          if (m_cnt_s != 3'h7) m_cnt_s++;
          if (m_miss == 7) begin
            m_state = 2'd1; m_oos = 1'b1; m_seed = 1'b0; m_miss = 0;
          end else m_miss++;
        end
      end
      if (err_clr) begin m_cnt = '0; m_cnt_s = '0; end
      m_pred = pn;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [42:0] exp_q [$];
  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  int ph;

  // Called at a falling edge; drives one cycle and scores its outputs.
  task automatic step(input logic v, input logic [15:0] d);
    logic [42:0] o, e;
    adc_valid = v;
    adc_data  = d;
    model_update(v, d);
    exp_q.push_back({m_state, m_oos, m_err, m_cnt, m_cnt_s, m_state, m_oos, m_err});
    @(posedge clk);
    #1;
    o = {pn_state, pn_oos, pn_err, err_count, err_count_s, pn_state_s, pn_oos_s, pn_err_s};
    e = exp_q.pop_front();
    chk("sb", 64'(o), 64'(e));
    @(negedge clk);
  endtask

  task automatic gold(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, gw(ph));
      ph++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, errs, rose, fell, unlocked;

    for (int i = 0; i < 7; i++) seq[i] = (i == 0);
    for (int i = 7; i < 127; i++) seq[i] = seq[i-7] ^ seq[i-6];
    n_cmp = 0; n_bad = 0; ph = 37;

    reset = 1'b1; cfg_enable = 1'b0; err_clr = 1'b0;
    adc_valid = 1'b0; adc_data = '0;
    @(negedge clk);
    step(1'b1, 16'hABCD);
    step(1'b0, 16'h0);
    reset = 1'b0;
    chk("rst_state", 64'(pn_state), 64'd0);
    chk("rst_oos", 64'(pn_oos), 64'd1);
    chk("rst_cnt", 64'(err_count), 64'd0);

    // Lock acquisition: one seed word plus 16 matches.
    cfg_enable = 1'b1;
    step(1'b0, 16'h0);
    chk("search_state", 64'(pn_state), 64'd1);
    n = 0;
    while (pn_oos && n < 60) begin step(1'b1, gw(ph)); ph++; n++; end
    chk("lock_len", 64'(n), 64'd17);
    chk("lock_state", 64'(pn_state), 64'd2);
    chk("lock_cnt", 64'(err_count), 64'd0);

    // Single-bit error while locked.
    gold(5);
    step(1'b1, gw(ph) ^ 16'h0008); ph++;
    chk("inj_err", 64'(pn_err), 64'd1);
    gold(1);
    chk("inj_err_pulse", 64'(pn_err), 64'd0);
    gold(4);
    chk("inj_cnt", 64'(err_count), 64'd1);
    chk("inj_oos", 64'(pn_oos), 64'd0);

    // Phase jump by 5 words: 8 errors, drop lock, relock after 17 words.
    ph += 5;
    errs = 0; rose = -1; fell = -1;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, gw(ph)); ph++;
      errs += int'(pn_err);
      if (pn_oos && rose < 0) rose = i;
      if (!pn_oos && rose >= 0 && fell < 0) fell = i;
    end
    chk("oos_errs", 64'(errs), 64'd8);
    chk("oos_rise", 64'(rose), 64'd7);
    chk("relock_len", 64'(fell - rose), 64'd17);
    chk("oos_cnt", 64'(err_count), 64'd9);

    // cfg_enable dropped while locked.
    cfg_enable = 1'b0;
    step(1'b1, gw(ph)); ph++;
    chk("dis_state", 64'(pn_state), 64'd0);
    chk("dis_cnt", 64'(err_count), 64'd9);

    // Gapped valid with garbage on idle cycles.
    cfg_enable = 1'b1;
    step(1'b0, 16'h0);
    n = 0;
    while (pn_oos && n < 60) begin
      step(1'b1, gw(ph)); ph++; n++;
      step(1'b0, 16'($urandom_range(0, 65535)));
    end
    chk("gap_lock_len", 64'(n), 64'd17);
    chk("gap_cnt", 64'(err_count), 64'd9);

    // Saturation on the 3-bit instance: reach 6 (all-ones - 1), then 3 errors.
    err_clr = 1'b1; gold(1); err_clr = 1'b0;
    chk("clr_cnt", 64'(err_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, gw(ph) ^ 16'h0008); ph++;
      gold(2);
    end
    chk("sat_pre", 64'(err_count_s), 64'd6);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, gw(ph) ^ 16'h0008); ph++;
      gold(2);
    end
    chk("sat_small", 64'(err_count_s), 64'd7);
    chk("sat_big", 64'(err_count), 64'd9);
    chk("sat_oos", 64'(pn_oos), 64'd0);

    // err_clr in the same cycle as an error: clear wins.
    err_clr = 1'b1;
    step(1'b1, gw(ph) ^ 16'h0008); ph++;
    err_clr = 1'b0;
    chk("clr_err_pulse", 64'(pn_err), 64'd1);
    chk("clr_win", 64'(err_count), 64'd0);
    gold(2);

    // Constant all-zero input never locks.
    cfg_enable = 1'b0; step(1'b0, 16'h0);
    cfg_enable = 1'b1; step(1'b0, 16'h0);
    unlocked = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 16'h0000);
      if (pn_oos) unlocked++;
    end
    chk("zero_oos", 64'(unlocked), 64'd40);
    chk("zero_state", 64'(pn_state), 64'd1);

    // Relock, take one error, then reset while locked.
    n = 0;
    while (pn_oos && n < 60) begin step(1'b1, gw(ph)); ph++; n++; end
    chk("relock2_len", 64'(n), 64'd17);
    step(1'b1, gw(ph) ^ 16'h0008); ph++;
    chk("pre_rst_cnt", 64'(err_count), 64'd1);
    reset = 1'b1;
    step(1'b1, gw(ph)); ph++;
    reset = 1'b0;
    chk("mid_rst_state", 64'(pn_state), 64'd0);
    chk("mid_rst_oos", 64'(pn_oos), 64'd1);
    chk("mid_rst_cnt", 64'(err_count), 64'd0);
    gold(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
